// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the spiking neuron datapath.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} syn_state_t;

  // Accumulator width that can hold n signed d-bit terms without overflow.
  function automatic int acc_bits_for(input int n, input int d);
    return d + $clog2(n) + 1;
  endfunction

  // Generic signed clamp to the range of a bits-wide two's complement value.
  function automatic logic signed [63:0] sat_to_bits(input logic signed [63:0] value,
                                                     input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Spike-vector input, weight-write port and weighted-sum output of the synapse stage.
interface synapse_accumulator_if #(
  parameter int n_inputs  = 4,
  parameter int data_bits = 4
);
  localparam int AW = $clog2(n_inputs);

  logic [n_inputs-1:0]         spikes_in;
  logic                        spikes_valid;
  logic                        spikes_ready;
  logic                        w_we;
  logic [AW-1:0]               w_addr;
  logic signed [data_bits-1:0] w_data;
  logic signed [data_bits-1:0] sum_out;
  logic                        sum_valid;
  logic                        sum_ready;

  modport master (
    output spikes_in, spikes_valid, w_we, w_addr, w_data, sum_ready,
    input  spikes_ready, sum_out, sum_valid
  );

  modport slave (
    input  spikes_in, spikes_valid, w_we, w_addr, w_data, sum_ready,
    output spikes_ready, sum_out, sum_valid
  );
endinterface

// File: rtl/weight_bank.sv
// Synaptic weight register file: synchronous write, combinational read, reset to zero.
module weight_bank #(
  parameter int n_inputs  = 4,
  parameter int data_bits = 4,
  parameter int AW        = $clog2(n_inputs)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic signed [data_bits-1:0] wdata,
  input  logic [AW-1:0]               raddr,
  output logic signed [data_bits-1:0] rdata
);

  logic signed [data_bits-1:0] mem [n_inputs];

  // Addresses beyond the last synapse exist only when n_inputs is not a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n_inputs; i++) mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < (AW + 1)'(n_inputs))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synapse_accumulator.sv
// Serial weighted sum of a spike vector, one synapse per clock, saturated to data_bits.
module synapse_accumulator
  import neuron_pkg::*;
#(
  parameter int n_inputs  = 4,
  parameter int data_bits = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  synapse_accumulator_if.slave  bus
);

  localparam int AW    = $clog2(n_inputs);
  localparam int ACC_W = acc_bits_for(n_inputs, data_bits);

  syn_state_t                  state;
  logic [AW-1:0]               idx;
  logic [n_inputs-1:0]         spk;
  logic signed [ACC_W-1:0]     acc;
  logic signed [data_bits-1:0] sum_reg;
  logic                        sum_vld;

  logic signed [data_bits-1:0] w_rd;
  logic signed [ACC_W-1:0]     term;
  logic signed [ACC_W-1:0]     next_acc;
  logic                        last;

  weight_bank #(
    .n_inputs  (n_inputs),
    .data_bits (data_bits),
    .AW        (AW)
  ) u_weights (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.w_we),
    .waddr (bus.w_addr),
    .wdata (bus.w_data),
    .raddr (idx),
    .rdata (w_rd)
  );

  assign term     = spk[idx] ? ACC_W'(w_rd) : '0;
  assign next_acc = acc + term;
  assign last     = (idx == AW'(n_inputs - 1));

  assign bus.spikes_ready = (state == IDLE) && !rst;
  assign bus.sum_out      = sum_reg;
  assign bus.sum_valid    = sum_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      spk     <= '0;
      acc     <= '0;
      sum_reg <= '0;
      sum_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.spikes_valid) begin
            spk   <= bus.spikes_in;
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= next_acc;
          // The final term is folded straight into the output so the result lands this edge.
          if (last) begin
            sum_reg <= data_bits'(sat_to_bits(64'(next_acc), data_bits));
            sum_vld <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.sum_ready) begin
            sum_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed checks of synapse_accumulator with 4 synapses and with 3 synapses.
module tb_synapse_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  synapse_accumulator_if #(.n_inputs(4), .data_bits(4)) bus_a ();
  synapse_accumulator_if #(.n_inputs(3), .data_bits(4)) bus_b ();

  synapse_accumulator #(.n_inputs(4), .data_bits(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  synapse_accumulator #(.n_inputs(3), .data_bits(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_a(input int a, input int v);
    bus_a.w_we   = 1'b1;
    bus_a.w_addr = 2'(a);
    bus_a.w_data = 4'(v);
    tick();
    bus_a.w_we = 1'b0;
  endtask

  task automatic wr_b(input int a, input int v);
    bus_b.w_we   = 1'b1;
    bus_b.w_addr = 2'(a);
    bus_b.w_data = 4'(v);
    tick();
    bus_b.w_we = 1'b0;
  endtask

  // Accepts one vector; an optional weight write is placed in the cycle where idx==1.
  task automatic vec_a(input logic [3:0] spk, input bit mid_we, input int maddr,
                       input int mdata, output int c);
    check_eq("a_ready_idle", int'(bus_a.spikes_ready), 1);
    bus_a.spikes_in    = spk;
    bus_a.spikes_valid = 1'b1;
    tick();
    bus_a.spikes_valid = 1'b0;
    check_eq("a_ready_accum", int'(bus_a.spikes_ready), 0);
    tick();
    c = 1;
    if (mid_we) begin
      bus_a.w_we   = 1'b1;
      bus_a.w_addr = 2'(maddr);
      bus_a.w_data = 4'(mdata);
    end
    tick();
    c = 2;
    bus_a.w_we = 1'b0;
    while (!bus_a.sum_valid && c < 20) begin
      tick();
      c++;
    end
  endtask

  // Same for the 3-input instance; the optional write lands in the cycle where idx==2.
  task automatic vec_b(input logic [2:0] spk, input bit mid_we, input int maddr,
                       input int mdata, output int c);
    bus_b.spikes_in    = spk;
    bus_b.spikes_valid = 1'b1;
    tick();
    bus_b.spikes_valid = 1'b0;
    tick();
    tick();
    c = 2;
    if (mid_we) begin
      bus_b.w_we   = 1'b1;
      bus_b.w_addr = 2'(maddr);
      bus_b.w_data = 4'(mdata);
    end
    while (!bus_b.sum_valid && c < 20) begin
      tick();
      c++;
      bus_b.w_we = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_a.spikes_in = '0; bus_a.spikes_valid = 1'b0; bus_a.w_we = 1'b0;
    bus_a.w_addr = '0; bus_a.w_data = '0; bus_a.sum_ready = 1'b1;
    bus_b.spikes_in = '0; bus_b.spikes_valid = 1'b0; bus_b.w_we = 1'b0;
    bus_b.w_addr = '0; bus_b.w_data = '0; bus_b.sum_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_ready", int'(bus_a.spikes_ready), 0);
    check_eq("rst_valid", int'(bus_a.sum_valid), 0);
    check_eq("rst_sum", int'(bus_a.sum_out), 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", int'(bus_a.spikes_ready), 1);

    // Basic sum: 3 + 2 + (-1) = 4
    wr_a(0, 3); wr_a(1, 2); wr_a(2, -1); wr_a(3, 5);
    vec_a(4'b0111, 1'b0, 0, 0, cyc);
    check_eq("t1_latency", cyc, 4);
    check_eq("t1_sum", int'(bus_a.sum_out), 4);
    tick();
    check_eq("t1_valid_drop", int'(bus_a.sum_valid), 0);
    check_eq("t1_ready_back", int'(bus_a.spikes_ready), 1);

    // Saturation at both rails and the empty vector
    wr_a(0, 7); wr_a(1, 7); wr_a(2, 7); wr_a(3, 7);
    vec_a(4'b1111, 1'b0, 0, 0, cyc);
    check_eq("t2_pos_sat", int'(bus_a.sum_out), 7);
    tick();
    wr_a(0, -8); wr_a(1, -8); wr_a(2, -8); wr_a(3, -8);
    vec_a(4'b1111, 1'b0, 0, 0, cyc);
    check_eq("t2_neg_sat", int'(bus_a.sum_out), -8);
    tick();
    vec_a(4'b0000, 1'b0, 0, 0, cyc);
    check_eq("t2_zero", int'(bus_a.sum_out), 0);
    tick();

    // Backpressure: result held, stray vector ignored
    bus_a.sum_ready = 1'b0;
    vec_a(4'b0001, 1'b0, 0, 0, cyc);
    check_eq("t3_latency", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_valid", int'(bus_a.sum_valid), 1);
      check_eq("t3_hold_sum", int'(bus_a.sum_out), -8);
      check_eq("t3_ready_low", int'(bus_a.spikes_ready), 0);
      if (i == 1) begin
        bus_a.spikes_in    = 4'b1111;
        bus_a.spikes_valid = 1'b1;
      end
      tick();
      bus_a.spikes_valid = 1'b0;
    end
    bus_a.sum_ready = 1'b1;
    tick();
    check_eq("t3_release_valid", int'(bus_a.sum_valid), 0);
    check_eq("t3_release_ready", int'(bus_a.spikes_ready), 1);
    repeat (6) tick();
    check_eq("t3_no_queued", int'(bus_a.sum_valid), 0);

    // Mid-accumulation weight writes
    wr_a(0, 1); wr_a(1, 1); wr_a(2, 1); wr_a(3, 1);
    vec_a(4'b1111, 1'b1, 3, 6, cyc);
    check_eq("t4_late_write", int'(bus_a.sum_out), 7);
    tick();
    wr_a(3, 1);
    vec_a(4'b1111, 1'b1, 0, 6, cyc);
    check_eq("t4_early_write", int'(bus_a.sum_out), 4);
    tick();
    vec_a(4'b1111, 1'b0, 0, 0, cyc);
    check_eq("t4_next_vector", int'(bus_a.sum_out), 7);
    tick();

    // Reset during accumulation; a simultaneous write loses to reset
    bus_a.spikes_in    = 4'b1111;
    bus_a.spikes_valid = 1'b1;
    tick();
    bus_a.spikes_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bus_a.w_we = 1'b1; bus_a.w_addr = 2'd0; bus_a.w_data = 4'sd5;
    tick();
    check_eq("t5_valid", int'(bus_a.sum_valid), 0);
    check_eq("t5_sum", int'(bus_a.sum_out), 0);
    rst = 1'b0;
    bus_a.w_we = 1'b0;
    tick();
    check_eq("t5_idle", int'(bus_a.spikes_ready), 1);
    check_eq("t5_no_result", int'(bus_a.sum_valid), 0);
    vec_a(4'b1111, 1'b0, 0, 0, cyc);
    check_eq("t5_latency", cyc, 4);
    check_eq("t5_zero_weights", int'(bus_a.sum_out), 0);
    tick();

    // Three-input instance: out-of-range write, same-cycle read/write
    wr_b(0, 1); wr_b(1, 1); wr_b(2, 2); wr_b(3, 7);
    vec_b(3'b111, 1'b1, 2, -4, cyc);
    check_eq("t6_latency", cyc, 3);
    check_eq("t6_old_value", int'(bus_b.sum_out), 4);
    tick();
    check_eq("t6_valid_drop", int'(bus_b.sum_valid), 0);
    vec_b(3'b111, 1'b0, 0, 0, cyc);
    check_eq("t6_new_value", int'(bus_b.sum_out), -2);
    vec_b(3'b100, 1'b0, 0, 0, cyc);
    tick();
    vec_b(3'b100, 1'b0, 0, 0, cyc);
    check_eq("t6_single", int'(bus_b.sum_out), -4);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
